// File: rtl/spi_tx_stream_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// spi_tx_pkg
// Shared definitions for the FIFO-buffered serial transmitter.
//   - 2-bit FSM state codes (IDLE/SHIFT/GAP; code 3 is unused)
//   - frame_len(): bits per serial frame (address + payload + optional parity)
//   - clog2(): width helper for pointer, level and counter vectors
// No ports: this is a package.
// ----------------------------------------------------------------------------
package spi_tx_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   function automatic int frame_len(input int addr_w, input int data_w, input bit parity);
      return addr_w + data_w + (parity ? 1 : 0);
   endfunction

   // Smallest r with 2**r >= value; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/spi_tx_stream_ctrl_if.sv
// ----------------------------------------------------------------------------
// spi_tx_stream_ctrl_if
// Bundles the word-input, back-pressure, serial-output and status signals of
// spi_tx_stream_ctrl.
//   master : the producer/receiver side (drives DATA, ENA, RX_STOP)
//   slave  : the transmitter (drives TX_DATA, TX_LOAD, OVERFLOW, LEVEL, state_mon)
// Handshake: ENA is a one-cycle write strobe with no ready return; a word is
// taken when ENA is high and the FIFO is not full (or is popping the same
// cycle), otherwise it is dropped and OVERFLOW latches. RX_STOP is an
// active-high "not ready" that only gates the start of the next frame.
// ----------------------------------------------------------------------------
interface spi_tx_stream_ctrl_if #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 16
);
   localparam int LEVEL_W = spi_tx_pkg::clog2(FIFO_DEPTH) + 1;

   logic [DATA_W-1:0]  DATA;
   logic               ENA;
   logic               RX_STOP;
   logic               TX_DATA;
   logic               TX_LOAD;
   logic               OVERFLOW;
   logic [LEVEL_W-1:0] LEVEL;
   logic [1:0]         state_mon;

   modport master (
      output DATA, ENA, RX_STOP,
      input  TX_DATA, TX_LOAD, OVERFLOW, LEVEL, state_mon
   );

   modport slave (
      input  DATA, ENA, RX_STOP,
      output TX_DATA, TX_LOAD, OVERFLOW, LEVEL, state_mon
   );

endinterface

// File: rtl/spi_tx_stream_ctrl_fifo.sv
// ----------------------------------------------------------------------------
// spi_tx_fifo
// First-word-fall-through FIFO, DATA_W x DEPTH (DEPTH a power of 2, >= 2).
// rd_data always shows the head word while !empty; a write never bypasses to
// the read side in the same cycle.
// Ports:
//   TX_CLK, RST   clock, synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data write strobe and word; accepted if !full or popping now
//   rd_en         pop the head word (ignored when empty)
//   rd_data       head word
//   full, empty   status
//   count         occupancy 0..DEPTH
//   overflow_evt  one-cycle flag: write dropped because full and not popping
// ----------------------------------------------------------------------------
module spi_tx_fifo
   import spi_tx_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic                  TX_CLK,
   input  logic                  RST,
   input  logic                  wr_en,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rd_en,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [clog2(DEPTH):0] count,
   output logic                  overflow_evt
);
   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;

   assign empty        = (count == '0);
   assign full         = (count == CNT_W'(DEPTH));
   assign pop          = rd_en && !empty;
   // When full, a same-cycle pop frees the slot the write lands in.
   assign push         = wr_en && (!full || pop);
   assign overflow_evt = wr_en && full && !pop;
   assign rd_data      = mem[rd_ptr];

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge TX_CLK) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge TX_CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of 2.
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_tx_stream_ctrl.sv
// ----------------------------------------------------------------------------
// spi_tx_stream_ctrl
// FIFO-buffered serial transmitter. Queued DATA_W-bit words are framed as
// {ADDR_VAL, word} and shifted out MSB first on TX_DATA, with TX_LOAD high
// during the last bit and GAP_CYCLES idle cycles after every frame. RX_STOP
// holds off the start of the next frame but never cuts a frame short.
// Build option: define SPI_TX_PARITY_EN to append an even-parity bit
// (XOR of address and data) after the data LSB; TX_LOAD then marks it.
// Ports:
//   TX_CLK  single clock, rising edge
//   RST     synchronous active-high reset; aborts any frame in flight
//   bus     spi_tx_stream_ctrl_if.slave: DATA/ENA/RX_STOP in,
//           TX_DATA/TX_LOAD/OVERFLOW/LEVEL/state_mon out
// ----------------------------------------------------------------------------
module spi_tx_stream_ctrl
   import spi_tx_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 3,
   parameter int ADDR_VAL   = 1,
   parameter int GAP_CYCLES = 1
) (
   input  logic TX_CLK,
   input  logic RST,
   spi_tx_stream_ctrl_if.slave bus
);
`ifdef SPI_TX_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif
   localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W, PARITY_EN);
   localparam int BODY_W    = ADDR_W + DATA_W;
   localparam int CNT_W     = clog2(FRAME_LEN + 1);
   localparam int GAP_W     = clog2(GAP_CYCLES + 1);
   localparam int LEVEL_W   = clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
   localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

   logic [1:0]           state_q;
   logic [1:0]           state_d;
   logic [CNT_W-1:0]     bit_cnt_q;
   logic [GAP_W-1:0]     gap_cnt_q;
   logic [FRAME_LEN-1:0] sreg_q;
   logic [FRAME_LEN-1:0] load_word;
   logic [BODY_W-1:0]    body;

   logic [DATA_W-1:0]    fifo_rd_data;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [LEVEL_W-1:0]   fifo_count;
   logic                 fifo_ovf_evt;

   logic                 pop;
   logic                 tx_data;
   logic                 tx_load;
   logic                 overflow_q;

   spi_tx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .TX_CLK       (TX_CLK),
      .RST          (RST),
      .wr_en        (bus.ENA),
      .wr_data      (bus.DATA),
      .rd_en        (pop),
      .rd_data      (fifo_rd_data),
      .full         (fifo_full),
      .empty        (fifo_empty),
      .count        (fifo_count),
      .overflow_evt (fifo_ovf_evt)
   );

   // Frame image loaded into the shifter: address prefix (if any) above the word.
   generate
      if (ADDR_W > 0) begin : g_addr
         localparam logic [ADDR_W-1:0] ADDR_BITS = ADDR_W'(ADDR_VAL);
         assign body = {ADDR_BITS, fifo_rd_data};
      end else begin : g_no_addr
         assign body = fifo_rd_data;
      end
   endgenerate

`ifdef SPI_TX_PARITY_EN
   assign load_word = {body, ^body};
`else
   assign load_word = body;
`endif

   // ---- FSM: state register ----
   always_ff @(posedge TX_CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE:  state_d = (!fifo_empty && !bus.RX_STOP) ? ST_SHIFT : ST_IDLE;
         ST_SHIFT: state_d = (bit_cnt_q == LAST_BIT) ? ST_GAP : ST_SHIFT;
         ST_GAP:   state_d = (gap_cnt_q == LAST_GAP) ? ST_IDLE : ST_GAP;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      pop     = 1'b0;
      tx_data = 1'b0;
      tx_load = 1'b0;
      case (state_q)
         // RX_STOP only matters here, so a frame in flight always completes.
         ST_IDLE:  pop = !fifo_empty && !bus.RX_STOP;
         ST_SHIFT: begin
            tx_data = sreg_q[FRAME_LEN-1];
            tx_load = (bit_cnt_q == LAST_BIT);
         end
         default: ;
      endcase
   end

   // ---- Shifter and counters ----
   always_ff @(posedge TX_CLK) begin
      if (RST) begin
         sreg_q    <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               bit_cnt_q <= '0;
               gap_cnt_q <= '0;
               if (pop) sreg_q <= load_word;
            end
            ST_SHIFT: begin
               sreg_q    <= {sreg_q[FRAME_LEN-2:0], 1'b0};
               bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
            end
            ST_GAP: begin
               gap_cnt_q <= (gap_cnt_q == LAST_GAP) ? '0 : gap_cnt_q + GAP_W'(1);
            end
            default: begin
               bit_cnt_q <= '0;
               gap_cnt_q <= '0;
            end
         endcase
      end
   end

   // Sticky until reset.
   always_ff @(posedge TX_CLK) begin
      if (RST)               overflow_q <= 1'b0;
      else if (fifo_ovf_evt) overflow_q <= 1'b1;
   end

   assign bus.TX_DATA   = tx_data;
   assign bus.TX_LOAD   = tx_load;
   assign bus.OVERFLOW  = overflow_q;
   assign bus.LEVEL     = fifo_count;
   assign bus.state_mon = state_q;

endmodule

// File: tb/tb_spi_tx_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_tx_stream_ctrl
// Self-checking bench for spi_tx_stream_ctrl. A negedge monitor rebuilds each
// serial frame and compares it with the frame expected for the next queued
// word; a linear directed sequence covers reset, latency, throughput,
// back-pressure, overflow, reset abort and randomized traffic.
// Honours SPI_TX_PARITY_EN in its expected frame length and content.
// ----------------------------------------------------------------------------
module tb_spi_tx_stream_ctrl;
   localparam int DATA_W     = 16;
   localparam int FIFO_DEPTH = 16;
   localparam int ADDR_W     = 3;
   localparam int ADDR_VAL   = 1;
   localparam int GAP_CYCLES = 1;
`ifdef SPI_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL     = ADDR_W + DATA_W + PAR;
   localparam int PERIOD = 1 + FL + GAP_CYCLES;

   // ---- clock / reset ----
   logic TX_CLK;
   logic RST;

   initial TX_CLK = 1'b0;
   always #5 TX_CLK = ~TX_CLK;

   spi_tx_stream_ctrl_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

   spi_tx_stream_ctrl #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_W     (ADDR_W),
      .ADDR_VAL   (ADDR_VAL),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .TX_CLK (TX_CLK),
      .RST    (RST),
      .bus    (bus)
   );

   // ---- scoreboard state ----
   int                tests = 0;
   int                fails = 0;
   int                cyc = 0;
   int                frames_done = 0;
   int                load_cnt = 0;
   int                lvl_max = 0;
   int                nbits = 0;
   logic [63:0]       frame_bits = '0;
   logic [DATA_W-1:0] exp_q[$];
   int                start_q[$];

   always @(posedge TX_CLK) cyc++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected frame: address above the word, optional even-parity bit below.
   function automatic logic [63:0] exp_frame(input logic [DATA_W-1:0] w);
      logic [63:0] f;
      f = ((64'(ADDR_VAL) & ((64'd1 << ADDR_W) - 64'd1)) << DATA_W) | 64'(w);
      if (PAR != 0) f = (f << 1) | 64'($countones(f) % 2);
      return f;
   endfunction

   // ---- monitor: rebuild frames from the serial line ----
   always @(negedge TX_CLK) begin
      if (RST) begin
         nbits = 0;
      end else begin
         if (int'(bus.LEVEL) > lvl_max) lvl_max = int'(bus.LEVEL);
         if (bus.state_mon == 2'd1) begin
            if (nbits == 0) start_q.push_back(cyc);
            frame_bits = {frame_bits[62:0], bus.TX_DATA};
            nbits++;
         end else begin
            check("no_truncation", 64'(nbits), 64'd0);
            check("idle_line_low", 64'(bus.TX_DATA), 64'd0);
            nbits = 0;
         end
         if (bus.TX_LOAD) begin
            load_cnt++;
            check("load_in_shift", 64'(bus.state_mon), 64'd1);
            check("frame_length", 64'(nbits), 64'(FL));
            if (exp_q.size() == 0) begin
               check("unexpected_frame", 64'(exp_q.size()), 64'd1);
            end else begin
               check("frame_content", frame_bits & ((64'd1 << FL) - 64'd1),
                     exp_frame(exp_q.pop_front()));
            end
            frames_done++;
            nbits = 0;
         end
      end
   end

   // ---- driver tasks ----
   task automatic tick();
      @(posedge TX_CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      bus.ENA = 1'b0;
      bus.RX_STOP = 1'b0;
      bus.DATA = '0;
      tick();
      tick();
      @(negedge TX_CLK);
      check("rst_tx_data", 64'(bus.TX_DATA), 64'd0);
      check("rst_tx_load", 64'(bus.TX_LOAD), 64'd0);
      check("rst_overflow", 64'(bus.OVERFLOW), 64'd0);
      check("rst_level", 64'(bus.LEVEL), 64'd0);
      check("rst_state", 64'(bus.state_mon), 64'd0);
      tick();
      RST = 1'b0;
      exp_q.delete();
   endtask

   // Starts at a drive point; returns at the negedge where state_mon == s.
   task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
      int n;
      n = 0;
      @(negedge TX_CLK);
      while (bus.state_mon !== s && n < budget) begin
         tick();
         @(negedge TX_CLK);
         n++;
      end
      check(tag, 64'(bus.state_mon), 64'(s));
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int n;
      n = 0;
      @(negedge TX_CLK);
      while (!(exp_q.size() == 0 && bus.state_mon == 2'd0) && n < budget) begin
         tick();
         @(negedge TX_CLK);
         n++;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   // One word into an idle, empty transmitter, checked cycle by cycle.
   task automatic single_frame(input logic [DATA_W-1:0] w);
      logic [63:0] f;
      f = exp_frame(w);
      bus.ENA = 1'b1;
      bus.DATA = w;
      exp_q.push_back(w);
      @(negedge TX_CLK);
      check("c0_state_idle", 64'(bus.state_mon), 64'd0);
      tick();
      bus.ENA = 1'b0;
      @(negedge TX_CLK);
      check("c1_level_one", 64'(bus.LEVEL), 64'd1);
      check("c1_state_idle", 64'(bus.state_mon), 64'd0);
      tick();
      for (int i = 0; i < FL; i++) begin
         @(negedge TX_CLK);
         check("bit_value", 64'(bus.TX_DATA), 64'(f[FL-1-i]));
         check("bit_load", 64'(bus.TX_LOAD), 64'(i == FL - 1));
         tick();
      end
      for (int g = 0; g < GAP_CYCLES; g++) begin
         @(negedge TX_CLK);
         check("gap_state", 64'(bus.state_mon), 64'd2);
         check("gap_line_low", 64'(bus.TX_DATA), 64'd0);
         tick();
      end
      @(negedge TX_CLK);
      check("after_gap_idle", 64'(bus.state_mon), 64'd0);
      check("after_level", 64'(bus.LEVEL), 64'd0);
   endtask

   // ---- directed + random sequence ----
   initial begin
      int fd0;
      int ld0;
      int n;
      int k;
      RST = 1'b1;
      bus.ENA = 1'b0;
      bus.RX_STOP = 1'b0;
      bus.DATA = '0;

      // 1: reset, then a single word with exact latency and bit pattern
      do_reset();
      single_frame(16'hA5C3);

      // 2: three words back to back, frames one PERIOD apart
      tick();
      start_q.delete();
      lvl_max = 0;
      fd0 = frames_done;
      for (int i = 0; i < 3; i++) begin
         bus.DATA = DATA_W'($urandom);
         bus.ENA = 1'b1;
         exp_q.push_back(bus.DATA);
         tick();
      end
      bus.ENA = 1'b0;
      wait_drain(4 * PERIOD, "t2_drain");
      check("t2_frames", 64'(frames_done - fd0), 64'd3);
      check("t2_starts", 64'(start_q.size()), 64'd3);
      if (start_q.size() == 3) begin
         check("t2_spacing_1", 64'(start_q[1] - start_q[0]), 64'(PERIOD));
         check("t2_spacing_2", 64'(start_q[2] - start_q[1]), 64'(PERIOD));
      end
      check("t2_level_peak", 64'(lvl_max), 64'd2);
      check("t2_level_end", 64'(bus.LEVEL), 64'd0);

      // 3: RX_STOP raised mid-frame; frame 2 waits, then starts one cycle after release
      tick();
      fd0 = frames_done;
      for (int i = 0; i < 2; i++) begin
         bus.DATA = DATA_W'($urandom);
         bus.ENA = 1'b1;
         exp_q.push_back(bus.DATA);
         tick();
      end
      bus.ENA = 1'b0;
      wait_state(2'd1, 10, "t3_frame1_start");
      tick();
      bus.RX_STOP = 1'b1;
      wait_state(2'd0, 2 * PERIOD, "t3_back_idle");
      check("t3_frame1_done", 64'(frames_done - fd0), 64'd1);
      check("t3_level_held", 64'(bus.LEVEL), 64'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge TX_CLK);
         check("t3_stalled", 64'(bus.state_mon), 64'd0);
      end
      tick();
      bus.RX_STOP = 1'b0;
      @(negedge TX_CLK);
      check("t3_release_cycle", 64'(bus.state_mon), 64'd0);
      tick();
      @(negedge TX_CLK);
      check("t3_frame2_start", 64'(bus.state_mon), 64'd1);
      tick();
      wait_drain(2 * PERIOD, "t3_drain");
      check("t3_frames", 64'(frames_done - fd0), 64'd2);

      // 4: 17 writes with RX_STOP held -> full, overflow, 17th word lost
      tick();
      do_reset();
      bus.RX_STOP = 1'b1;
      fd0 = frames_done;
      for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
         bus.DATA = DATA_W'($urandom);
         bus.ENA = 1'b1;
         if (i < FIFO_DEPTH) exp_q.push_back(bus.DATA);
         if (i == FIFO_DEPTH) begin
            @(negedge TX_CLK);
            check("t4_full_level", 64'(bus.LEVEL), 64'(FIFO_DEPTH));
            check("t4_no_ovf_yet", 64'(bus.OVERFLOW), 64'd0);
         end
         tick();
      end
      bus.ENA = 1'b0;
      @(negedge TX_CLK);
      check("t4_level", 64'(bus.LEVEL), 64'(FIFO_DEPTH));
      check("t4_overflow", 64'(bus.OVERFLOW), 64'd1);
      check("t4_still_idle", 64'(bus.state_mon), 64'd0);
      tick();
      bus.RX_STOP = 1'b0;
      wait_drain((FIFO_DEPTH + 2) * PERIOD, "t4_drain");
      check("t4_frames", 64'(frames_done - fd0), 64'(FIFO_DEPTH));
      check("t4_ovf_sticky", 64'(bus.OVERFLOW), 64'd1);
      check("t4_level_end", 64'(bus.LEVEL), 64'd0);

      // 5: reset at bit 8 aborts the frame with no TX_LOAD
      tick();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         bus.DATA = DATA_W'($urandom);
         bus.ENA = 1'b1;
         exp_q.push_back(bus.DATA);
         tick();
      end
      bus.ENA = 1'b0;
      wait_state(2'd1, 10, "t5_frame_start");
      for (int i = 0; i < 8; i++) tick();
      RST = 1'b1;
      tick();
      @(negedge TX_CLK);
      check("t5_tx_data", 64'(bus.TX_DATA), 64'd0);
      check("t5_tx_load", 64'(bus.TX_LOAD), 64'd0);
      check("t5_level", 64'(bus.LEVEL), 64'd0);
      check("t5_state", 64'(bus.state_mon), 64'd0);
      exp_q.delete();
      ld0 = load_cnt;
      tick();
      RST = 1'b0;
      for (int i = 0; i < 3 * PERIOD; i++) tick();
      @(negedge TX_CLK);
      check("t5_no_late_load", 64'(load_cnt - ld0), 64'd0);
      check("t5_idle_after", 64'(bus.state_mon), 64'd0);

      // 6: 0x0001 with address 1 (parity bit 0 when parity is built in)
      tick();
      do_reset();
      single_frame(16'h0001);

      // random traffic with random back-pressure
      for (int r = 0; r < 6; r++) begin
         tick();
         fd0 = frames_done;
         n = $urandom_range(1, 6);
         k = 0;
         while (k < n) begin
            bus.RX_STOP = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
               bus.DATA = DATA_W'($urandom);
               bus.ENA = 1'b1;
               exp_q.push_back(bus.DATA);
               k++;
            end else begin
               bus.ENA = 1'b0;
            end
            tick();
         end
         bus.ENA = 1'b0;
         bus.RX_STOP = 1'b0;
         wait_drain((n + 2) * PERIOD + 20, "rnd_drain");
         check("rnd_frames", 64'(frames_done - fd0), 64'(n));
         check("rnd_no_overflow", 64'(bus.OVERFLOW), 64'd0);
         check("rnd_level_end", 64'(bus.LEVEL), 64'd0);
      end

      // ---- report ----
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
